// File: rtl/md_scheduler.sv
// Multiply/divide scheduler: owns HI/LO, runs the mult/div busy window, and raises the HI/LO stall.
// Latency: a start sampled at edge t0 lands HI/LO after edge t0+N (N = MULT_CYCLES or DIV_CYCLES); mthi/mtlo land after 1 edge.
// Backpressure: stall_md holds a HI/LO-using D-stage instruction while busy or while a start is in E; starts and writes seen during RUN are ignored.
//
// Ports:
//   clk, reset (async, active-low)
//   E_md_start / E_md_op[1:0]  : mult(00) multu(01) div(10) divu(11) issued from E
//   E_md_wr / E_md_wr_hi       : mthi (wr_hi=1) / mtlo (wr_hi=0) issued from E
//   E_A, E_B [31:0]            : forwarded rs / rt operands
//   D_MD_yes                   : D-stage instruction touches HI/LO or the unit
//   busy, stall_md             : unit in flight / stall request to the hazard unit
//   HI, LO [31:0]              : architectural HI/LO
//
// Optional feature macro: MDU_DIV0_SKIP_EN
//   defined   : div/divu by zero is dropped (no RUN, HI/LO unchanged)
//   undefined : div/divu by zero runs DIV_CYCLES, then HI=E_A, LO=0xFFFFFFFF

module md_scheduler #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_md_start,
  input  logic [1:0]  E_md_op,
  input  logic        E_md_wr,
  input  logic        E_md_wr_hi,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        D_MD_yes,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;

  // ------------------------------------------------------------------
  // Result datapath (evaluated from the E-stage operands at start time)
  // ------------------------------------------------------------------
  logic        is_div;
  logic        is_unsigned;
  logic        div_by_zero;
  logic        div0_skip;
  logic [63:0] a_ext, b_ext, product;
  logic [31:0] abs_a, abs_b;
  logic [31:0] dvd, dvs;
  logic [31:0] q_mag, r_mag;
  logic [31:0] div_q, div_r;
  logic [31:0] res_hi, res_lo;

  assign is_div      = E_md_op[1];
  assign is_unsigned = E_md_op[0];
  assign div_by_zero = is_div & (E_B == 32'd0);

`ifdef MDU_DIV0_SKIP_EN
  assign div0_skip = div_by_zero;
`else
  assign div0_skip = 1'b0;
`endif

  // Sign- or zero-extend to 64 bits; the low 64 bits of the product are
  // then the correct signed or unsigned result without signed arithmetic.
  assign a_ext   = is_unsigned ? {32'd0, E_A} : {{32{E_A[31]}}, E_A};
  assign b_ext   = is_unsigned ? {32'd0, E_B} : {{32{E_B[31]}}, E_B};
  assign product = a_ext * b_ext;

  // Signed divide is done on magnitudes with sign fix-up afterwards.
  // This gives truncation toward zero and a remainder carrying the
  // dividend's sign, and naturally yields 0x80000000 / -1 = 0x80000000
  // with remainder 0 (|0x80000000| is still 0x80000000 as unsigned).
  assign abs_a = E_A[31] ? 32'(~E_A + 32'd1) : E_A;
  assign abs_b = E_B[31] ? 32'(~E_B + 32'd1) : E_B;
  assign dvd   = is_unsigned ? E_A : abs_a;
  // Divisor forced non-zero so the divider never sees x/0; the
  // divide-by-zero result is substituted below.
  assign dvs   = (E_B == 32'd0) ? 32'd1 : (is_unsigned ? E_B : abs_b);
  assign q_mag = dvd / dvs;
  assign r_mag = dvd % dvs;

  always_comb begin
    div_q = q_mag;
    div_r = r_mag;
    if (!is_unsigned) begin
      if (E_A[31] ^ E_B[31]) div_q = 32'(~q_mag + 32'd1);
      if (E_A[31])           div_r = 32'(~r_mag + 32'd1);
    end
  end

  always_comb begin
    res_hi = product[63:32];
    res_lo = product[31:0];
    if (is_div) begin
      if (div_by_zero) begin
        res_hi = E_A;
        res_lo = 32'hFFFF_FFFF;
      end else begin
        res_hi = div_r;
        res_lo = div_q;
      end
    end
  end

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;

    if (state_q == IDLE) begin
      if (E_md_start) begin
        // Start wins over a simultaneous mthi/mtlo; the write is dropped.
        if (!div0_skip) begin
          state_d   = RUN;
          cnt_d     = is_div ? DIV_CNT : MULT_CNT;
          pend_hi_d = res_hi;
          pend_lo_d = res_lo;
        end
      end else if (E_md_wr) begin
        if (E_md_wr_hi) hi_d = E_A;
        else            lo_d = E_A;
      end
    end else begin
      // RUN ignores new starts/writes; only the countdown advances.
      if (cnt_q == 4'd1) begin
        hi_d    = pend_hi_q;
        lo_d    = pend_lo_q;
        cnt_d   = 4'd0;
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end
  end

  // ------------------------------------------------------------------
  // State registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign busy     = (state_q == RUN);
  // A start in E already blocks D, covering the cycle before busy rises.
  assign stall_md = D_MD_yes & (busy | E_md_start);
  assign HI       = hi_q;
  assign LO       = lo_q;

endmodule

// File: tb/tb_md_scheduler.sv
// Directed bench for md_scheduler: reset, mult/multu/div/divu results, busy window and stall length,
// start/write collisions, in-RUN pokes, mthi/mtlo, divide by zero and reset mid-operation.
// Inputs are driven 1 time unit after the rising edge; outputs are checked 2 units after it.

module tb_md_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        E_md_start;
  logic [1:0]  E_md_op;
  logic        E_md_wr;
  logic        E_md_wr_hi;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        D_MD_yes;
  logic        busy;
  logic        stall_md;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_err = 0;
  int n_chk = 0;

  // Expected architectural HI/LO, maintained by the bench.
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  md_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .E_md_start (E_md_start),
    .E_md_op    (E_md_op),
    .E_md_wr    (E_md_wr),
    .E_md_wr_hi (E_md_wr_hi),
    .E_A        (E_A),
    .E_B        (E_B),
    .D_MD_yes   (D_MD_yes),
    .busy       (busy),
    .stall_md   (stall_md),
    .HI         (HI),
    .LO         (LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one mult/div, hold D_MD_yes throughout, and check the busy
  // window, the stall length (n+1) and the final HI/LO. With poke set,
  // a divu start plus an mthi are thrown at the unit mid-RUN.
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input int n, input logic [31:0] eh, input logic [31:0] el,
                        input bit poke);
    int stalls;
    stalls     = 0;
    E_md_start = 1'b1;
    E_md_op    = op;
    E_A        = a;
    E_B        = b;
    D_MD_yes   = 1'b1;
    #1;
    chk({tag, "_busy_pre"}, {31'd0, busy}, 32'd0);
    if (stall_md) stalls++;
    tick();
    E_md_start = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (poke && k == 1) begin
        E_md_start = 1'b1;
        E_md_op    = 2'b11;
        E_A        = 32'h0000_0099;
        E_B        = 32'h0000_0003;
        E_md_wr    = 1'b1;
        E_md_wr_hi = 1'b1;
      end
      #1;
      chk({tag, "_busy_run"}, {31'd0, busy}, 32'd1);
      chk({tag, "_hi_hold"}, HI, m_hi);
      if (stall_md) stalls++;
      tick();
      E_md_start = 1'b0;
      E_md_wr    = 1'b0;
    end
    #1;
    chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    chk({tag, "_stall_done"}, {31'd0, stall_md}, 32'd0);
    chk({tag, "_stall_cycles"}, 32'(stalls), 32'(n + 1));
    chk({tag, "_hi"}, HI, eh);
    chk({tag, "_lo"}, LO, el);
    m_hi     = eh;
    m_lo     = el;
    D_MD_yes = 1'b0;
  endtask

  initial begin
    reset      = 1'b0;
    E_md_start = 1'b0;
    E_md_op    = 2'b00;
    E_md_wr    = 1'b0;
    E_md_wr_hi = 1'b0;
    E_A        = 32'd0;
    E_B        = 32'd0;
    D_MD_yes   = 1'b0;

    // Reset state
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stall", {31'd0, stall_md}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    D_MD_yes   = 1'b1;
    E_md_start = 1'b1;
    #1;
    chk("rst_stall_start", {31'd0, stall_md}, 32'd1);
    E_md_start = 1'b0;
    #1;
    chk("stall_idle_no_start", {31'd0, stall_md}, 32'd0);
    D_MD_yes = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    // mult / multu, the latter with a start+mthi poked in mid-RUN
    run_op("mult",  2'b00, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
    run_op("multu", 2'b01, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA, 1'b1);

    // div / divu / overflow case (back-to-back, no dead cycle)
    run_op("div",    2'b10, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu",   2'b11, 32'd7, 32'd2, 10, 32'd1, 32'd3, 1'b0);
    run_op("div_ov", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000, 1'b0);

    // mtlo while idle
    E_md_wr    = 1'b1;
    E_md_wr_hi = 1'b0;
    E_A        = 32'h0000_1234;
    tick();
    E_md_wr = 1'b0;
    #1;
    chk("mtlo_lo", LO, 32'h0000_1234);
    chk("mtlo_hi", HI, 32'd0);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);
    m_lo = 32'h0000_1234;

    // start and mthi together: only the mult result lands
    E_md_start = 1'b1;
    E_md_op    = 2'b00;
    E_md_wr    = 1'b1;
    E_md_wr_hi = 1'b1;
    E_A        = 32'd3;
    E_B        = 32'd4;
    tick();
    E_md_start = 1'b0;
    E_md_wr    = 1'b0;
    #1;
    chk("collide_hi_nowrite", HI, 32'd0);
    chk("collide_busy", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 4; k++) tick();
    #1;
    chk("collide_busy_last", {31'd0, busy}, 32'd1);
    tick();
    #1;
    chk("collide_busy_done", {31'd0, busy}, 32'd0);
    chk("collide_hi", HI, 32'd0);
    chk("collide_lo", LO, 32'd12);
    m_hi = 32'd0;
    m_lo = 32'd12;

    // divide by zero
`ifdef MDU_DIV0_SKIP_EN
    E_md_start = 1'b1;
    E_md_op    = 2'b10;
    E_A        = 32'd5;
    E_B        = 32'd0;
    D_MD_yes   = 1'b1;
    #1;
    chk("div0_stall", {31'd0, stall_md}, 32'd1);
    tick();
    E_md_start = 1'b0;
    #1;
    chk("div0_busy", {31'd0, busy}, 32'd0);
    chk("div0_stall_after", {31'd0, stall_md}, 32'd0);
    tick();
    #1;
    chk("div0_hi", HI, 32'd0);
    chk("div0_lo", LO, 32'd12);
    D_MD_yes = 1'b0;
`else
    run_op("div0", 2'b10, 32'd5, 32'd0, 10, 32'd5, 32'hFFFF_FFFF, 1'b0);
`endif

    // reset mid-RUN: make HI non-zero first, then start a mult and reset
    E_md_wr    = 1'b1;
    E_md_wr_hi = 1'b1;
    E_A        = 32'h0000_0077;
    tick();
    E_md_wr = 1'b0;
    #1;
    chk("mthi_77", HI, 32'h0000_0077);
    E_md_start = 1'b1;
    E_md_op    = 2'b00;
    E_A        = 32'd2;
    E_B        = 32'd3;
    tick();
    E_md_start = 1'b0;
    tick();
    #1;
    chk("rstmid_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_hi", HI, 32'd0);
    chk("rstmid_lo", LO, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    #1;
    chk("rstmid_stays_idle", {31'd0, busy}, 32'd0);
    E_md_wr    = 1'b1;
    E_md_wr_hi = 1'b1;
    E_A        = 32'd5;
    tick();
    E_md_wr = 1'b0;
    #1;
    chk("post_rst_mthi", HI, 32'd5);
    chk("post_rst_lo", LO, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
